calc_op_sequencer: RTL

//  Top-level control sequencer for the calculator datapath.

---
 rtl/calc_op_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/calc_op_sequencer.sv
// Calculator control sequencer: operand A -> opcode -> operand B -> execute -> show.
// Optional CALC_CHAIN_EN: an op pulse in S_SHOW reuses the low half of the result as operand A.
module calc_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enter,
  input  logic               add,
  input  logic               sub,
  input  logic               mult,
  input  logic [WIDTH-1:0]   data_in,
  output logic [2:0]         state,
  output logic [1:0]         op_code,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_NONE0 = 3'd0,
    S_A     = 3'd1,
    S_B     = 3'd2,
    S_OP    = 3'd3,
    S_EXEC  = 3'd4,
    S_MUL   = 3'd5,
    S_NONE6 = 3'd6,
    S_SHOW  = 3'd7
  } state_t;

  state_t             st, st_nxt;
  logic [WIDTH-1:0]   a_reg, a_nxt, b_reg, b_nxt;
  logic [2*WIDTH-1:0] mul_a, mul_a_nxt, acc, acc_nxt, res_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [1:0]         op_nxt, sel_op;
  logic               ovf_nxt, done_nxt, chained, chained_nxt, any_op;

  // mult > sub > add when several pulses coincide
  assign any_op = add | sub | mult;
  assign sel_op = mult ? 2'b11 : sub ? 2'b10 : add ? 2'b01 : 2'b00;

  always_comb begin
    st_nxt      = st;
    a_nxt       = a_reg;
    b_nxt       = b_reg;
    mul_a_nxt   = mul_a;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    op_nxt      = op_code;
    res_nxt     = result;
    ovf_nxt     = overflow;
    done_nxt    = 1'b0;
    chained_nxt = chained;
    case (st)
      S_A: if (enter) begin
        a_nxt  = data_in;
        st_nxt = S_OP;
      end
      S_OP: if (any_op) begin
        op_nxt = sel_op;
        st_nxt = S_B;
      end
      S_B: if (enter) begin
        b_nxt = data_in;
        if (op_code == 2'b11) begin
          st_nxt    = S_MUL;
          cnt_nxt   = CW'(WIDTH);
          acc_nxt   = '0;
          mul_a_nxt = {{WIDTH{1'b0}}, a_reg};
        end else begin
          st_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_code == 2'b10) begin
          res_nxt = {{WIDTH{1'b0}}, a_reg} - {{WIDTH{1'b0}}, b_reg};
          ovf_nxt = (a_reg < b_reg) | chained;
        end else begin
          res_nxt = {{WIDTH{1'b0}}, a_reg} + {{WIDTH{1'b0}}, b_reg};
          ovf_nxt = chained;
        end
        done_nxt = 1'b1;
        st_nxt   = S_SHOW;
      end
      S_MUL: begin
        // WIDTH shift-add steps, then one cycle to publish the accumulator
        if (cnt != '0) begin
          if (b_reg[0]) acc_nxt = acc + mul_a;
          mul_a_nxt = mul_a << 1;
          b_nxt     = b_reg >> 1;
          cnt_nxt   = cnt - 1'b1;
        end else begin
          res_nxt  = acc;
          ovf_nxt  = chained;
          done_nxt = 1'b1;
          st_nxt   = S_SHOW;
        end
      end
      S_SHOW: begin
        if (enter) begin
          st_nxt      = S_A;
          op_nxt      = 2'b00;
          chained_nxt = 1'b0;
        end
`ifdef CALC_CHAIN_EN
        else if (any_op) begin
          a_nxt       = result[WIDTH-1:0];
          op_nxt      = sel_op;
          ovf_nxt     = |result[2*WIDTH-1:WIDTH];
          chained_nxt = |result[2*WIDTH-1:WIDTH];
          st_nxt      = S_B;
        end
`endif
      end
      default: st_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st       <= S_A;
      a_reg    <= '0;
      b_reg    <= '0;
      mul_a    <= '0;
      acc      <= '0;
      cnt      <= '0;
      op_code  <= 2'b00;
      result   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      chained  <= 1'b0;
    end else begin
      st       <= st_nxt;
      a_reg    <= a_nxt;
      b_reg    <= b_nxt;
      mul_a    <= mul_a_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      op_code  <= op_nxt;
      result   <= res_nxt;
      overflow <= ovf_nxt;
      done     <= done_nxt;
      chained  <= chained_nxt;
    end
  end

  assign state = st;
  assign busy  = (st == S_EXEC) || (st == S_MUL);

endmodule
